// File: rtl/knn_pkg.sv
// Shared defaults, FSM state encoding and width helpers for the KNN vote stage.
package knn_pkg;

  localparam int N_DEF = 64;
  localparam int B_DEF = 32;
  localparam int K_DEF = 5;
  localparam int C_DEF = 8;

  localparam int CNT_W = $clog2(K_DEF + 1);
  localparam int IDX_W = $clog2(K_DEF + 1);
  localparam int CLS_W = $clog2(C_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SELECT = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Index/count width that never collapses to zero bits for tiny K or C.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/knn_vote_bank.sv
// Per-class vote counters and first-seen rank registers; single-cycle update, combinational read.
// No backpressure: clear has priority over increment, both land on the next edge.
module knn_vote_bank
  import knn_pkg::*;
#(
  parameter  int K  = K_DEF,
  parameter  int C  = C_DEF,
  localparam int VW = width_of(K + 1),
  localparam int LW = width_of(C)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [LW-1:0] inc_cls,
  input  logic [VW-1:0] inc_idx,
  input  logic [LW-1:0] rd_cls,
  output logic [VW-1:0] rd_cnt,
  output logic [VW-1:0] rd_rank
);

  logic [VW-1:0] cnt_q  [C];
  logic [VW-1:0] rank_q [C];

  // A rank of K marks a class that has not been seen in the current run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < C; c++) begin
        cnt_q[c]  <= '0;
        rank_q[c] <= '0;
      end
    end else if (clr) begin
      for (int c = 0; c < C; c++) begin
        cnt_q[c]  <= '0;
        rank_q[c] <= VW'(K);
      end
    end else if (inc) begin
      cnt_q[inc_cls] <= cnt_q[inc_cls] + 1'b1;
      if (rank_q[inc_cls] == VW'(K)) rank_q[inc_cls] <= inc_idx;
    end
  end

  assign rd_cnt  = cnt_q[rd_cls];
  assign rd_rank = rank_q[rd_cls];

endmodule

// File: rtl/knn_vote.sv
// Majority vote over the K nearest sorted labels; class_valid pulses K+C+1 edges after a start.
// No backpressure: a rising valid_sort while busy is dropped, never queued.
module knn_vote
  import knn_pkg::*;
#(
  parameter  int N  = N_DEF,
  parameter  int B  = B_DEF,
  parameter  int K  = K_DEF,
  parameter  int C  = C_DEF,
  localparam int VW = width_of(K + 1),
  localparam int LW = width_of(C)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_sort,
  input  logic [N*B-1:0] type_array_sorted,
  output logic [B-1:0]   class_out,
  output logic [VW-1:0]  vote_count,
  output logic           class_valid,
  output logic           invalid_label,
  output logic           busy
);

  state_t        state;
  logic          valid_sort_q;
  logic [B-1:0]  entry_buf [K];
  logic [VW-1:0] idx;
  logic [LW-1:0] sel;
  logic          bad_q;
  logic [LW-1:0] best_cls;
  logic [VW-1:0] best_cnt;
  logic [VW-1:0] best_rank;
  logic [VW-1:0] rd_cnt;
  logic [VW-1:0] rd_rank;
  logic [B-1:0]  lbl;
  logic          lbl_ok;
  logic          start;
  logic          take;
  logic          unused_tail;

  assign unused_tail = ^(type_array_sorted >> (K * B));

  assign start  = (state == IDLE) && valid_sort && !valid_sort_q;
  assign lbl    = entry_buf[idx];
  assign lbl_ok = lbl < B'(C);

  // Strictly more votes wins; equal non-zero votes go to the class seen nearest.
  assign take = (rd_cnt > best_cnt) ||
                ((rd_cnt == best_cnt) && (rd_cnt != '0) && (rd_rank < best_rank));

  knn_vote_bank #(.K(K), .C(C)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .inc     ((state == COUNT) && lbl_ok),
    .inc_cls (lbl[LW-1:0]),
    .inc_idx (idx),
    .rd_cls  (sel),
    .rd_cnt  (rd_cnt),
    .rd_rank (rd_rank)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      valid_sort_q  <= 1'b0;
      idx           <= '0;
      sel           <= '0;
      bad_q         <= 1'b0;
      best_cls      <= '0;
      best_cnt      <= '0;
      best_rank     <= '0;
      class_out     <= '0;
      vote_count    <= '0;
      class_valid   <= 1'b0;
      invalid_label <= 1'b0;
      busy          <= 1'b0;
      for (int i = 0; i < K; i++) entry_buf[i] <= '0;
    end else begin
      valid_sort_q <= valid_sort;
      class_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < K; i++) entry_buf[i] <= type_array_sorted[i*B +: B];
            idx   <= '0;
            bad_q <= 1'b0;
            busy  <= 1'b1;
            state <= COUNT;
          end
        end
        COUNT: begin
          if (!lbl_ok) bad_q <= 1'b1;
          if (idx == VW'(K - 1)) begin
            idx       <= '0;
            sel       <= '0;
            best_cls  <= '0;
            best_cnt  <= '0;
            best_rank <= VW'(K);
            state     <= SELECT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SELECT: begin
          if (take) begin
            best_cls  <= sel;
            best_cnt  <= rd_cnt;
            best_rank <= rd_rank;
          end
          if (sel == LW'(C - 1)) begin
            sel   <= '0;
            state <= DONE;
          end else begin
            sel <= sel + 1'b1;
          end
        end
        DONE: begin
          class_out     <= B'(best_cls);
          vote_count    <= best_cnt;
          invalid_label <= bad_q;
          class_valid   <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Randomized and directed bench for knn_vote against a plain-arithmetic vote model.
`timescale 1ns/1ps
module tb_knn_vote;

  localparam int N  = 64;
  localparam int B  = 32;
  localparam int K  = 5;
  localparam int C  = 8;
  localparam int VW = $clog2(K + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           valid_sort = 1'b0;
  logic [N*B-1:0] type_array_sorted = '0;
  logic [B-1:0]   class_out;
  logic [VW-1:0]  vote_count;
  logic           class_valid;
  logic           invalid_label;
  logic           busy;

  int n_chk = 0;
  int n_bad = 0;

  int unsigned lab [K];
  int          lat;
  int          pulses;
  logic [B-1:0]  got_cls;
  logic [VW-1:0] got_cnt;
  logic          got_inv;
  int          exp_cls;
  int          exp_cnt;
  bit          exp_inv;

  always #5 clk = ~clk;

  knn_vote #(.N(N), .B(B), .K(K), .C(C)) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_sort        (valid_sort),
    .type_array_sorted (type_array_sorted),
    .class_out         (class_out),
    .vote_count        (vote_count),
    .class_valid       (class_valid),
    .invalid_label     (invalid_label),
    .busy              (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Winner = most votes; among tied classes, the one whose label appears first in rank order.
  task automatic model();
    int  cnt [C];
    bit  found;
    exp_inv = 1'b0;
    exp_cnt = 0;
    exp_cls = 0;
    found   = 1'b0;
    for (int c = 0; c < C; c++) cnt[c] = 0;
    for (int i = 0; i < K; i++) begin
      if (lab[i] < C) cnt[lab[i]]++;
      else exp_inv = 1'b1;
    end
    for (int c = 0; c < C; c++) if (cnt[c] > exp_cnt) exp_cnt = cnt[c];
    for (int i = 0; i < K; i++) begin
      if (!found && exp_cnt > 0 && lab[i] < C && cnt[lab[i]] == exp_cnt) begin
        exp_cls = int'(lab[i]);
        found   = 1'b1;
      end
    end
  endtask

  task automatic load();
    for (int i = 0; i < N; i++)
      type_array_sorted[i*B +: B] = (i < K) ? B'(lab[i]) : B'($urandom);
  endtask

  // Called right after the start edge (+#1). mode 0: drop valid_sort early,
  // 1: hold it high all window, 2: re-pulse it while the vote scan is running.
  task automatic watch(input string tag, input int win, input int mode);
    lat    = 0;
    pulses = 0;
    for (int k = 1; k <= win; k++) begin
      @(posedge clk); #1;
      if (class_valid) begin
        pulses++;
        if (lat == 0) begin
          lat     = k;
          got_cls = class_out;
          got_cnt = vote_count;
          got_inv = invalid_label;
        end
      end
      if (k == 2)
        for (int i = 0; i < N * B / 32; i++) type_array_sorted[i*32 +: 32] = $urandom;
      if (mode == 0 && k == 3) valid_sort = 1'b0;
      if (mode == 2 && k == 7) valid_sort = 1'b0;
      if (mode == 2 && k == 8) valid_sort = 1'b1;
    end
    model();
    chk({tag, " latency"}, 64'(lat), 64'd14);
    chk({tag, " pulses"}, 64'(pulses), 64'd1);
    chk({tag, " class_out"}, 64'(got_cls), 64'(exp_cls));
    chk({tag, " vote_count"}, 64'(got_cnt), 64'(exp_cnt));
    chk({tag, " invalid_label"}, 64'(got_inv), 64'(exp_inv));
    chk({tag, " hold"}, 64'(class_out), 64'(exp_cls));
    valid_sort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int win, input int mode);
    load();
    @(negedge clk);
    valid_sort = 1'b1;
    @(posedge clk); #1;
    chk({tag, " busy"}, 64'(busy), 64'd1);
    watch(tag, win, mode);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset class_out", 64'(class_out), 64'd0);
    chk("reset vote_count", 64'(vote_count), 64'd0);
    chk("reset class_valid", 64'(class_valid), 64'd0);
    chk("reset invalid", 64'(invalid_label), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    lab = '{3, 3, 5, 3, 2}; run("basic", 40, 0);
    chk("basic const class", 64'(got_cls), 64'd3);
    chk("basic const votes", 64'(got_cnt), 64'd3);

    // Abort in the middle of COUNT, then restart straight out of reset.
    lab = '{3, 3, 5, 3, 2};
    load();
    @(negedge clk);
    valid_sort = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst class_out", 64'(class_out), 64'd0);
    chk("midrst vote_count", 64'(vote_count), 64'd0);
    chk("midrst class_valid", 64'(class_valid), 64'd0);
    chk("midrst invalid", 64'(invalid_label), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      chk("midrst no pulse", 64'(class_valid), 64'd0);
    end
    lab = '{6, 1, 6, 0, 7};
    load();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel busy", 64'(busy), 64'd1);
    watch("rst_rel", 40, 0);

    lab = '{2, 5, 5, 2, 1}; run("tie", 40, 0);
    chk("tie const class", 64'(got_cls), 64'd2);
    lab = '{4, 4, 4, 4, 4}; run("all4", 40, 0);
    chk("all4 const votes", 64'(got_cnt), 64'd5);
    lab = '{1, 0, 0, 6, 6}; run("tie2", 40, 0);
    chk("tie2 const class", 64'(got_cls), 64'd0);
    lab = '{9, 9, 9, 1, 1}; run("inv", 40, 0);
    chk("inv const class", 64'(got_cls), 64'd1);
    lab = '{9, 9, 9, 9, 9}; run("allinv", 40, 0);
    chk("allinv const inv", 64'(got_inv), 64'd1);

    lab = '{7, 2, 7, 2, 0}; run("pulse", 40, 2);
    lab = '{5, 6, 6, 5, 3}; run("hold", 100, 1);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < K; i++) lab[i] = $urandom_range(0, (r % 3 == 0) ? 9 : 4);
      run("rand", 40, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/knn_vote.md
Name: knn_vote

Overview:
- Final KNN stage; sits directly downstream of distance_sort.
- Consumes distance_sort's sorted type array and its valid_sort flag.
- Takes the K nearest entries, counts votes per class, resolves ties, and emits the predicted class with a one-cycle valid pulse.
- Processing is multi-cycle and sequential: one entry per cycle, then one class per cycle.

Parameters:
- N, 64, number of entries in the sorted array (matches distance_sort).
- B, 32, bit width of each type entry.
- K, 5, number of nearest neighbours voted; legal range 1 <= K <= N.
- C, 8, number of classes; legal labels are 0..C-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_sort  in  1  sorted array valid, from distance_sort; held high as a level.
- type_array_sorted  in  N*B  flattened sorted types; entry i at [i*B +: B]; entry 0 is the nearest.
- class_out  out  B  predicted class label.
- vote_count  out  $clog2(K+1)  number of votes for the winning class.
- class_valid  out  1  one-cycle pulse when class_out and vote_count update.
- invalid_label  out  1  set when any of the K entries had a label >= C; valid with class_valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; class_out, vote_count, class_valid, invalid_label and busy all 0.
  - Per-class counters and first-rank registers cleared; valid_sort_q=0.
  - If valid_sort is already high when reset releases, that counts as a rising edge and starts a run.
- Start:
  - valid_sort_q registers valid_sort each cycle.
  - A start is the clock edge in IDLE where valid_sort=1 and valid_sort_q=0.
  - At the start edge: latch entries 0..K-1 into an internal K*B buffer; clear counters, invalid flag and the index counter; first_rank[c] = K (meaning "unseen"); go to COUNT.
- COUNT, K cycles, idx = 0..K-1:
  - If label L = buf[idx] < C: cnt[L]++; if first_rank[L] == K, set first_rank[L] = idx.
  - If L >= C: set the sticky invalid flag; no counter changes.
  - When idx = K-1, go to SELECT.
- SELECT, C cycles, c = 0..C-1, running best (best_cls, best_cnt, best_rank) initialised to (0, 0, K):
  - Class c replaces the best if cnt[c] > best_cnt.
  - Or, on a tie, if cnt[c] == best_cnt, cnt[c] > 0 and first_rank[c] < best_rank.
  - Tie rule: the tied class whose nearest member ranks earliest wins.
  - After c = C-1, go to DONE.
- DONE, 1 cycle:
  - Register class_out = best_cls, vote_count = best_cnt, invalid_label = flag.
  - class_valid=1 for exactly this cycle; then go to IDLE.
- Latency: class_valid is high in the cycle beginning K+C+1 edges after the start edge (14 with defaults).
- All K labels invalid: class_out=0, vote_count=0, invalid_label=1.
- Counters are $clog2(K+1) bits wide and cannot overflow.
- Outputs hold the last result until the next DONE. class_valid is 0 in every other state.
- Rising edge of valid_sort while busy: ignored, not queued. valid_sort held high does not retrigger; it must fall and rise again.
- Input changes after the start edge have no effect; the buffer is private.
- Reset mid-run aborts immediately with no class_valid.

Decomposition:
- Package knn_pkg holds:
  - defaults for N, B, K, C;
  - the state encoding (IDLE, COUNT, SELECT, DONE; 2 bits);
  - width constants CNT_W = $clog2(K+1), IDX_W = $clog2(K+1), CLS_W = $clog2(C).
- One sub-module, knn_vote_bank: the C counters and C first_rank registers, with clear, increment(label, idx) and a read port indexed by c.
- FSM, buffer and argmax scan stay in knn_vote.

Test Plan:
- Entries 0..4 = 3,3,5,3,2; valid_sort 0->1 -> class_valid 14 cycles after the start edge; class_out=3, vote_count=3, invalid_label=0.
- Tie: entries = 2,5,5,2,1 -> class_out=2 (rank 0 beats 5 at rank 1), vote_count=2.
- Entries = 4,4,4,4,4 -> class_out=4, vote_count=5. Then a second run with 1,0,0,6,6 after valid_sort drops and re-rises -> class_out=0 (rank 1 beats 6 at rank 3), vote_count=2.
- Invalid labels: entries = 9,9,9,1,1 with C=8 -> class_out=1, vote_count=2, invalid_label=1. All entries 9 -> class_out=0, vote_count=0, invalid_label=1.
- rst=0 during COUNT -> all outputs 0 asynchronously and no class_valid. Release rst with valid_sort high -> new run; class_valid 14 cycles later.
- Pulse valid_sort 1->0->1 during SELECT -> ignored, only one class_valid. valid_sort held high 100 cycles -> exactly one class_valid.
